// File: rtl/ram_3.sv
`default_nettype none
// ============================================================================
// Module   : ram_3
// Brief    : 1024x8 single-port synchronous RAM with automatic zero-fill after
//            reset; ready rises once the sweep has cleared every word.
// Revision : 1.0 - initial release
// ============================================================================
module ram_3 #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              cs,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_cnt_last = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] c_cnt_one  = (ADDR_W+1)'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_next;
  logic [DATA_W-1:0] r_data_out;
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The sweep owns the array port in INIT; user strobes only matter in RUN.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_mem_we     = 1'b0;
    w_mem_addr   = addr;
    w_mem_wdata  = data_in;
    w_rd_en      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_cnt[ADDR_W-1:0];
        w_mem_wdata = '0;
        w_cnt_next  = r_cnt + c_cnt_one;
        if (r_cnt == c_cnt_last) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_mem_we = cs & wr;
        w_rd_en  = cs & rd & ~wr;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // No reset on the array: contents change only through the clocked port.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else if (w_rd_en) begin
      r_data_out <= r_mem[addr];
    end
  end

  assign data_out = r_data_out;
  assign ready    = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_ram_3.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_3
// Brief    : Directed self-checking bench for ram_3 with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_3;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              wr;
  logic              cs;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              ready;

  int n_tests;
  int n_fail;

  ram_3 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .cs       (cs),
    .rd       (rd),
    .data_out (data_out),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; data_in = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    cs = 1'b1; wr = 1'b0; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    d = data_out;
  endtask

  // Counts edges until ready rises, giving up after 2000 edges.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 2000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [DATA_W-1:0] rdat;
    logic [ADDR_W-1:0] a;
    int n;
    int low_seen;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0;
    addr = '0; data_in = '0;

    repeat (3) tick();
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);

    // Hammer addr 0 with writes/reads during the sweep; all must be ignored.
    rst_n = 1'b1;
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = '0; data_in = 8'hFF;
    n = 0;
    low_seen = 0;
    while (!ready && n < 2000) begin
      if (n == 600) wr = 1'b0;
      tick();
      n++;
      if (data_out != 8'h00) low_seen++;
    end
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    check("init_cycles", 32'(n), 32'd1024);
    check("init_data_out_held", 32'(low_seen), 32'd0);
    check("ready_run", 32'(ready), 32'h1);

    do_read(10'd0, rdat);    check("zero_0", 32'(rdat), 32'h00);
    do_read(10'd512, rdat);  check("zero_512", 32'(rdat), 32'h00);
    do_read(10'd1023, rdat); check("zero_1023", 32'(rdat), 32'h00);

    for (int k = 0; k < 1024; k++) begin
      do_write(ADDR_W'(k), DATA_W'((2 * k) % 256));
    end
    do_read(10'd5, rdat);    check("fill_5", 32'(rdat), 32'd10);
    do_read(10'd200, rdat);  check("fill_200", 32'(rdat), 32'd144);
    do_read(10'd1023, rdat); check("fill_1023", 32'(rdat), 32'd254);
    do_read(10'd128, rdat);  check("fill_128", 32'(rdat), 32'd0);
    for (int i = 0; i < 20; i++) begin
      a = ADDR_W'((i * 337 + 41) % 1024);
      do_read(a, rdat);
      check($sformatf("fill_rand_%0d", a), 32'(rdat), 32'((2 * a) % 256));
    end

    // cs low: the write to addr 7 and the later read must both be no-ops.
    cs = 1'b0; wr = 1'b1; rd = 1'b0; addr = 10'd7; data_in = 8'hAA;
    tick();
    wr = 1'b0;
    do_read(10'd7, rdat);    check("cs_gate_write", 32'(rdat), 32'd14);
    cs = 1'b0; rd = 1'b1; addr = 10'd3;
    tick();
    rd = 1'b0;
    check("cs_gate_read", 32'(data_out), 32'd14);

    do_read(10'd3, rdat);    check("latency_3", 32'(rdat), 32'd6);
    cs = 1'b1; addr = 10'd200;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_%0d", i), 32'(data_out), 32'd6);
    end
    cs = 1'b0;

    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 10'd9; data_in = 8'h55;
    tick();
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    check("collide_hold", 32'(data_out), 32'd6);
    do_read(10'd9, rdat);    check("collide_write", 32'(rdat), 32'h55);

    // Reset lands between edges partway through a new fill.
    for (int k = 0; k < 50; k++) begin
      do_write(ADDR_W'(k), DATA_W'(8'hC3 ^ k));
    end
    cs = 1'b1; wr = 1'b1; addr = 10'd50; data_in = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data_out", 32'(data_out), 32'h0);
    check("async_rst_ready", 32'(ready), 32'h0);
    cs = 1'b0; wr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready(n);
    check("reinit_cycles", 32'(n), 32'd1024);
    do_read(10'd0, rdat);    check("reinit_0", 32'(rdat), 32'h00);
    do_read(10'd25, rdat);   check("reinit_25", 32'(rdat), 32'h00);
    do_read(10'd49, rdat);   check("reinit_49", 32'(rdat), 32'h00);
    do_read(10'd9, rdat);    check("reinit_9", 32'(rdat), 32'h00);
    do_read(10'd1023, rdat); check("reinit_1023", 32'(rdat), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
